// File: rtl/bcp_pkg.sv
// Shared sizing constants, state encoding and helpers
// for the BCP unit scheduler.
package bcp_pkg;

  localparam int CLAUSE_NUM  = 8;
  localparam int VAR_NUM     = 7;
  localparam int VAR_NUM_LOG = 3;
  localparam int TRAIL_DEPTH = 7;
  localparam int CLAUSE_LOG  = $clog2(CLAUSE_NUM);
  localparam int CNT_W       = $clog2(TRAIL_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GRANT,
    S_CAPTURE,
    S_BT_POP,
    S_BT_PULSE
  } sched_state_e;

  // One-hot mask of a variable; out-of-range indices give zero.
  function automatic logic [VAR_NUM-1:0] var_mask(
    input logic [VAR_NUM_LOG-1:0] v
  );
    var_mask = VAR_NUM'(1) << v;
  endfunction

endpackage

// File: rtl/bcp_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after ptr_i, wrapping, by rotate then priority-encode.
module bcp_rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] win_o,
  output logic         valid_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    off     = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = W'(i);
        valid_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    win_o = sum[W-1:0];
  end

endmodule

// File: rtl/bcp_unit_scheduler.sv
// BCP scheduler: grants clause checkers round-robin, commits
// implied literals to a trail and unwinds them on backtrack.
module bcp_unit_scheduler
  import bcp_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bcp_start,
  input  logic                              backtrack_req,
  input  logic [CLAUSE_NUM-1:0]             unit_exist,
  input  logic [CLAUSE_NUM*VAR_NUM_LOG-1:0] implication_flat,
  input  logic [CLAUSE_NUM-1:0]             assign_value_in,
  output logic [CLAUSE_NUM-1:0]             checker_en,
  output logic                              backtrack_en,
  output logic [VAR_NUM-1:0]                free,
  output logic [VAR_NUM-1:0]                assignment,
  output logic                              busy,
  output logic                              op_done,
  output logic                              trail_empty,
  output logic                              overflow_err
);

  sched_state_e           state_q, state_d;
  logic [VAR_NUM-1:0]     free_q, free_d;
  logic [VAR_NUM-1:0]     asg_q, asg_d;
  logic [VAR_NUM_LOG-1:0] trail_q [TRAIL_DEPTH];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CLAUSE_LOG-1:0]  rr_q, rr_d;
  logic [CLAUSE_LOG-1:0]  win_q, win_d;
  logic [CLAUSE_LOG-1:0]  arb_win;
  logic [VAR_NUM_LOG-1:0] var_q, var_d;
  logic [VAR_NUM_LOG-1:0] impl_var, top_var;
  logic [VAR_NUM-1:0]     cap_mask, pop_mask;
  logic                   ovf_q, ovf_d;
  logic                   arb_valid, push, full;

  bcp_rr_arbiter #(
    .N(CLAUSE_NUM)
  ) u_arb (
    .req_i   (unit_exist),
    .ptr_i   (rr_q),
    .win_o   (arb_win),
    .valid_o (arb_valid)
  );

  assign impl_var = implication_flat[win_q*VAR_NUM_LOG +: VAR_NUM_LOG];
  assign top_var  = trail_q[cnt_q - CNT_W'(1)];
  assign full     = cnt_q == CNT_W'(TRAIL_DEPTH);
  assign cap_mask = var_mask(var_q);
  assign pop_mask = var_mask(top_var);

  always_comb begin
    state_d = state_q;
    free_d  = free_q;
    asg_d   = asg_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    win_d   = win_q;
    var_d   = var_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    op_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (backtrack_req) state_d = S_BT_POP;
        else if (bcp_start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (arb_valid) begin
          win_d   = arb_win;
          state_d = S_GRANT;
        end else begin
          op_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        var_d   = impl_var;
        rr_d    = (win_q == CLAUSE_LOG'(CLAUSE_NUM - 1))
                ? '0 : win_q + CLAUSE_LOG'(1);
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (full) begin
          ovf_d   = 1'b1;
          op_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          free_d  = free_q & ~cap_mask;
          asg_d   = (asg_q & ~cap_mask)
                  | ({VAR_NUM{assign_value_in[win_q]}} & cap_mask);
          push    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_SETTLE;
        end
      end
      S_BT_POP: begin
        if (cnt_q == '0) begin
          op_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          free_d  = free_q | pop_mask;
          asg_d   = asg_q & ~pop_mask;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_BT_PULSE;
        end
      end
      S_BT_PULSE: begin
        op_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      free_q  <= '1;
      asg_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      var_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      asg_q   <= asg_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      var_q   <= var_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TRAIL_DEPTH; i++) trail_q[i] <= '0;
    end else if (push) begin
      trail_q[cnt_q] <= var_q;
    end
  end

  assign checker_en   = (state_q == S_GRANT)
                      ? (CLAUSE_NUM'(1) << win_q) : '0;
  assign backtrack_en = state_q == S_BT_PULSE;
  assign busy         = state_q != S_IDLE;
  assign trail_empty  = cnt_q == '0;
  assign overflow_err = ovf_q;
  assign free         = free_q;
  assign assignment   = asg_q;

  // With a full trail every variable is assigned; that case
  // surfaces as overflow_err rather than a checker fault.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == S_GRANT && !full) |-> free_q[impl_var]);

endmodule

// File: tb/tb_bcp_unit_scheduler.sv
// Directed bench for bcp_unit_scheduler with a small
// behavioural stand-in for the clause checker array.
module tb_bcp_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bcp_start = 1'b0;
  logic        backtrack_req = 1'b0;
  logic [7:0]  unit_exist = '0;
  logic [23:0] implication_flat = '0;
  logic [7:0]  assign_value_in = '0;
  logic [7:0]  checker_en;
  logic        backtrack_en;
  logic [6:0]  free, assignment;
  logic        busy, op_done, trail_empty, overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcp_unit_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .bcp_start        (bcp_start),
    .backtrack_req    (backtrack_req),
    .unit_exist       (unit_exist),
    .implication_flat (implication_flat),
    .assign_value_in  (assign_value_in),
    .checker_en       (checker_en),
    .backtrack_en     (backtrack_en),
    .free             (free),
    .assignment       (assignment),
    .busy             (busy),
    .op_done          (op_done),
    .trail_empty      (trail_empty),
    .overflow_err     (overflow_err)
  );

  // Each model checker offers a list of literals, one per grant.
  int   lv [8][8];
  logic lb [8][8];
  int   ln [8];
  int   li [8];

  int         cyc, en_cyc, bt_cyc, both;
  logic [7:0] en_or;
  int         gq[$];

  typedef struct {
    bit         bt;
    int         ck;
    int         v;
    bit         b;
    logic [6:0] fr;
    logic [6:0] as;
    logic [7:0] en;
    int         btc;
    int         cy;
    bit         emp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_units();
    for (int k = 0; k < 8; k++) begin
      if (li[k] < ln[k]) begin
        unit_exist[k] = 1'b1;
        implication_flat[k*3 +: 3] = 3'(lv[k][li[k]]);
      end else begin
        unit_exist[k] = 1'b0;
        implication_flat[k*3 +: 3] = 3'd0;
      end
    end
  endtask

  task automatic clear_mock();
    for (int k = 0; k < 8; k++) begin
      ln[k] = 0;
      li[k] = 0;
      for (int j = 0; j < 8; j++) begin
        lv[k][j] = 0;
        lb[k][j] = 1'b0;
      end
    end
    drive_units();
  endtask

  task automatic load(input int k, input int v, input logic b);
    lv[k][ln[k]] = v;
    lb[k][ln[k]] = b;
    ln[k]++;
    drive_units();
  endtask

  // Advance one cycle; a granted checker registers its value on the en edge.
  task automatic tick();
    logic [7:0] en;
    en = checker_en;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (en[k] && li[k] < ln[k]) begin
        assign_value_in[k] = lb[k][li[k]];
        li[k]++;
      end
    end
    drive_units();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bcp_start = 1'b0;
    backtrack_req = 1'b0;
    clear_mock();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_op(input logic st, input logic bt);
    bit done;
    done   = 1'b0;
    cyc    = 0;
    en_cyc = 0;
    bt_cyc = 0;
    both   = 0;
    en_or  = '0;
    gq.delete();
    bcp_start     = st;
    backtrack_req = bt;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      if (checker_en != '0) begin
        en_cyc++;
        en_or |= checker_en;
        for (int k = 0; k < 8; k++)
          if (checker_en[k]) gq.push_back(k);
      end
      if (backtrack_en) bt_cyc++;
      if (backtrack_en && checker_en != '0) both++;
      if (op_done) done = 1'b1;
    end
    bcp_start     = 1'b0;
    backtrack_req = 1'b0;
    chk("op_done_seen", 32'(done), 1);
    chk("en_bt_overlap", both, 0);
    tick();
    chk("idle_after_op", 32'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{0, 2, 5, 1, 7'h5F, 7'h20, 8'h04, 0, 4, 0};
    tbl[1] = '{0, 6, 0, 0, 7'h5E, 7'h20, 8'h40, 0, 4, 0};
    tbl[2] = '{0, 0, 3, 1, 7'h56, 7'h28, 8'h01, 0, 4, 0};
    tbl[3] = '{1, 0, 0, 0, 7'h5E, 7'h20, 8'h00, 1, 2, 0};
    tbl[4] = '{1, 0, 0, 0, 7'h5F, 7'h20, 8'h00, 1, 2, 0};
    tbl[5] = '{0, 7, 6, 1, 7'h1F, 7'h60, 8'h80, 0, 4, 0};
    tbl[6] = '{1, 0, 0, 0, 7'h5F, 7'h20, 8'h00, 1, 2, 0};
    tbl[7] = '{1, 0, 0, 0, 7'h7F, 7'h00, 8'h00, 1, 2, 1};
    tbl[8] = '{1, 0, 0, 0, 7'h7F, 7'h00, 8'h00, 0, 1, 1};

    do_reset();
    chk("rst free", free, 7'h7F);
    chk("rst assignment", assignment, 0);
    chk("rst checker_en", checker_en, 0);
    chk("rst backtrack_en", 32'(backtrack_en), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst op_done", 32'(op_done), 0);
    chk("rst trail_empty", 32'(trail_empty), 1);
    chk("rst overflow", 32'(overflow_err), 0);

    foreach (tbl[i]) begin
      if (!tbl[i].bt) load(tbl[i].ck, tbl[i].v, tbl[i].b);
      run_op(!tbl[i].bt, tbl[i].bt);
      chk($sformatf("v%0d free", i), free, tbl[i].fr);
      chk($sformatf("v%0d asg", i), assignment, tbl[i].as);
      chk($sformatf("v%0d en", i), en_or, tbl[i].en);
      chk($sformatf("v%0d en_cyc", i), en_cyc,
          (tbl[i].en != 0) ? 1 : 0);
      chk($sformatf("v%0d bt_en", i), bt_cyc, tbl[i].btc);
      chk($sformatf("v%0d cycles", i), cyc, tbl[i].cy);
      chk($sformatf("v%0d empty", i), 32'(trail_empty), 32'(tbl[i].emp));
    end

    // Round-robin with checkers 0 and 7 requesting together.
    load(0, 0, 1'b1);
    load(0, 2, 1'b0);
    load(7, 1, 1'b1);
    run_op(1'b1, 1'b0);
    chk("rr grants", gq.size(), 3);
    chk("rr g0", (gq.size() > 0) ? gq[0] : 99, 0);
    chk("rr g1", (gq.size() > 1) ? gq[1] : 99, 7);
    chk("rr g2", (gq.size() > 2) ? gq[2] : 99, 0);
    chk("rr free", free, 7'h78);
    chk("rr asg", assignment, 7'h03);
    chk("rr cycles", cyc, 10);

    // Two implications then three backtracks.
    do_reset();
    load(3, 1, 1'b0);
    load(5, 4, 1'b1);
    run_op(1'b1, 1'b0);
    chk("bt setup free", free, 7'h6D);
    chk("bt setup asg", assignment, 7'h10);
    chk("bt setup cycles", cyc, 7);
    run_op(1'b0, 1'b1);
    chk("bt1 free", free, 7'h7D);
    chk("bt1 asg", assignment, 7'h00);
    chk("bt1 pulses", bt_cyc, 1);
    chk("bt1 empty", 32'(trail_empty), 0);
    run_op(1'b0, 1'b1);
    chk("bt2 free", free, 7'h7F);
    chk("bt2 empty", 32'(trail_empty), 1);
    run_op(1'b0, 1'b1);
    chk("bt3 pulses", bt_cyc, 0);
    chk("bt3 cycles", cyc, 1);

    // Start with no units pending.
    bcp_start = 1'b1;
    chk("nounit op_done c0", 32'(op_done), 0);
    tick();
    chk("nounit op_done c1", 32'(op_done), 1);
    chk("nounit en", checker_en, 0);
    bcp_start = 1'b0;
    tick();
    chk("nounit busy c2", 32'(busy), 0);
    chk("nounit op_done c2", 32'(op_done), 0);

    // Backtrack wins over a simultaneous start.
    load(1, 2, 1'b1);
    run_op(1'b1, 1'b0);
    chk("prio setup free", free, 7'h7B);
    load(4, 6, 1'b1);
    run_op(1'b1, 1'b1);
    chk("prio en", en_or, 0);
    chk("prio bt_en", bt_cyc, 1);
    chk("prio free", free, 7'h7F);
    chk("prio cycles", cyc, 2);
    clear_mock();

    // Fill the trail, then one more pending unit overflows it.
    for (int v = 0; v < 7; v++) load(5, v, 1'(v & 1));
    load(5, 3, 1'b1);
    run_op(1'b1, 1'b0);
    chk("ovf flag", 32'(overflow_err), 1);
    chk("ovf free", free, 7'h00);
    chk("ovf asg", assignment, 7'h2A);
    chk("ovf grants", en_cyc, 8);
    chk("ovf cycles", cyc, 24);
    chk("ovf empty", 32'(trail_empty), 0);

    // Asynchronous reset while a grant is in flight.
    clear_mock();
    load(2, 4, 1'b1);
    bcp_start = 1'b1;
    tick();
    tick();
    chk("rst mid en", checker_en, 8'h04);
    #2;
    rst = 1'b1;
    bcp_start = 1'b0;
    clear_mock();
    #1;
    chk("rst async busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst mid free", free, 7'h7F);
    chk("rst mid asg", assignment, 0);
    chk("rst mid en0", checker_en, 0);
    chk("rst mid busy", 32'(busy), 0);
    chk("rst mid empty", 32'(trail_empty), 1);
    chk("rst mid ovf", 32'(overflow_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
